// File: rtl/i2s_slave_rx_if.sv
// Parallel stereo-sample output bus of the I2S slave receiver: valid/ready
// handshake carrying the FIFO head pair.
interface i2s_slave_rx_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;

  modport master (output out_valid, output out_left, output out_right, input out_ready);
  modport slave  (input out_valid, input out_left, input out_right, output out_ready);
endinterface

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples SCK/WS/SD, deserializes MSB-first words with
// the 1-bit WS delay and queues left/right pairs in a small FIFO.
module i2s_slave_rx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        sck,
  input  logic                        ws,
  input  logic                        sd,
  i2s_slave_rx_if.master              out_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        short_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [6:0]  DW7     = 7'(DATA_W);

  typedef enum logic {ST_UNSYNC, ST_SYNC} state_e;

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic ws_s1_q, ws_s2_q, sd_s1_q, sd_s2_q;
  logic sck_rise;

  state_e            state_q, state_d;
  logic              ws_prev_q, ws_prev_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic              left_vld_q, left_vld_d;
  logic              short_q, short_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  logic              push, do_push, pop, full;
  logic [DATA_W-1:0] push_l, push_r;
  logic [DATA_W-1:0] word_nxt;
  logic [5:0]        cnt_nxt;

  assign sck_rise = sck_s2_q & ~sck_s3_q;

  always_comb begin
    state_d     = state_q;
    ws_prev_d   = ws_prev_q;
    bit_cnt_d   = bit_cnt_q;
    word_d      = word_q;
    left_hold_d = left_hold_q;
    left_vld_d  = left_vld_q;
    short_d     = 1'b0;
    push        = 1'b0;
    push_l      = left_hold_q;
    push_r      = '0;
    word_nxt    = word_q;
    cnt_nxt     = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;

    for (int unsigned i = 0; i < DATA_W; i++) begin
      if ({1'b0, bit_cnt_q} == 7'(DATA_W - 1 - i)) word_nxt[i] = sd_s2_q;
    end

    // ws_prev follows WS on every rise, even while disabled, so a re-enable
    // only resyncs on a genuine word boundary.
    if (!en) begin
      state_d    = ST_UNSYNC;
      left_vld_d = 1'b0;
      if (sck_rise) ws_prev_d = ws_s2_q;
    end else if (sck_rise) begin
      case (state_q)
        ST_UNSYNC: begin
          if (ws_s2_q != ws_prev_q) begin
            ws_prev_d = ws_s2_q;
            bit_cnt_d = '0;
            word_d    = '0;
            state_d   = ST_SYNC;
          end
        end
        ST_SYNC: begin
          word_d    = word_nxt;
          bit_cnt_d = cnt_nxt;
          if (ws_s2_q != ws_prev_q) begin
            short_d = ({1'b0, cnt_nxt} < DW7);
            if (!ws_prev_q) begin
              left_hold_d = word_nxt;
              left_vld_d  = 1'b1;
            end else if (left_vld_q) begin
              push       = 1'b1;
              push_r     = word_nxt;
              left_vld_d = 1'b0;
            end
            word_d    = '0;
            bit_cnt_d = '0;
            ws_prev_d = ws_s2_q;
          end
        end
        default: state_d = ST_UNSYNC;
      endcase
    end
  end

  always_comb begin
    pop      = (count_q != '0) && out_if.out_ready;
    full     = (count_q == DEPTH_C);
    do_push  = push && (!full || pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A new overflow wins over a simultaneous clear.
    if (push && full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
    else                      ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_s3_q    <= 1'b0;
      ws_s1_q     <= 1'b0;
      ws_s2_q     <= 1'b0;
      sd_s1_q     <= 1'b0;
      sd_s2_q     <= 1'b0;
      state_q     <= ST_UNSYNC;
      ws_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      word_q      <= '0;
      left_hold_q <= '0;
      left_vld_q  <= 1'b0;
      short_q     <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_l_q[i] <= '0;
        mem_r_q[i] <= '0;
      end
    end else begin
      sck_s1_q    <= sck;
      sck_s2_q    <= sck_s1_q;
      sck_s3_q    <= sck_s2_q;
      ws_s1_q     <= ws;
      ws_s2_q     <= ws_s1_q;
      sd_s1_q     <= sd;
      sd_s2_q     <= sd_s1_q;
      state_q     <= state_d;
      ws_prev_q   <= ws_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      word_q      <= word_d;
      left_hold_q <= left_hold_d;
      left_vld_q  <= left_vld_d;
      short_q     <= short_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (do_push) begin
        mem_l_q[wr_ptr_q] <= push_l;
        mem_r_q[wr_ptr_q] <= push_r;
      end
    end
  end

  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_left  = mem_l_q[rd_ptr_q];
  assign out_if.out_right = mem_r_q[rd_ptr_q];
  assign fifo_level       = count_q;
  assign overflow         = ovf_q;
  assign short_err        = short_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Bench for i2s_slave_rx: table-driven frames, hand-timed FIFO/reset/enable
// sequences and randomized word streams checked against a bit-level model.
module tb_i2s_slave_rx;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic sck = 1'b0, ws = 1'b0, sd = 1'b0, ovf_clr = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic overflow, short_err;

  i2s_slave_rx_if #(.DATA_W(DW)) rx_if ();

  i2s_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sck(sck), .ws(ws), .sd(sd),
    .out_if(rx_if), .fifo_level(fifo_level), .overflow(overflow),
    .ovf_clr(ovf_clr), .short_err(short_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rdy_mode = 0;            // 0: hold low, 1: always ready, 2: random, 3: manual
  int short_cnt = 0, short_base = 0;
  bit mon_r;

  logic [DW-1:0] exp_l[$], exp_r[$];

  // Word list -> transmitted (ws, sd) per SCK rise, with WS leading by one bit.
  logic [31:0] w_val[$];
  int          w_n[$];
  bit          w_ch[$];
  bit          b_ws[$], b_sd[$];

  // Reference model: per-rise rules applied to the bit stream.
  bit            m_en, m_sync, m_prev, m_lvld, m_push;
  bit            m_bits[$];
  logic [DW-1:0] m_lhold;
  int            m_short;

  typedef struct {
    logic [31:0] l_in;  int l_n;
    logic [31:0] r_in;  int r_n;
    logic [DW-1:0] exp_l; logic [DW-1:0] exp_r;
    int exp_short;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    m_sync = 0; m_prev = 0; m_lvld = 0; m_lhold = '0; m_short = 0;
    m_bits.delete();
  endfunction

  function automatic void model_final(bit ch);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < m_bits.size() && i < DW; i++) v[DW-1-i] = m_bits[i];
    if (m_bits.size() < DW) m_short++;
    if (!ch) begin
      m_lhold = v; m_lvld = 1;
    end else if (m_lvld) begin
      m_lvld = 0;
      if (m_push) begin exp_l.push_back(m_lhold); exp_r.push_back(v); end
    end
    m_bits.delete();
  endfunction

  function automatic void model_bit(bit w, bit d);
    if (m_en) begin
      if (!m_sync) begin
        if (w != m_prev) begin m_sync = 1; m_bits.delete(); end
      end else begin
        m_bits.push_back(d);
        if (w != m_prev) model_final(m_prev);
      end
    end
    m_prev = w;
  endfunction

  function automatic void add_word(bit ch, logic [31:0] v, int n);
    w_ch.push_back(ch); w_val.push_back(v); w_n.push_back(n);
  endfunction

  function automatic void build();
    bit chb[$];
    b_ws.delete(); b_sd.delete();
    foreach (w_val[i])
      for (int b = w_n[i] - 1; b >= 0; b--) begin
        chb.push_back(w_ch[i]);
        b_sd.push_back(w_val[i][b]);
      end
    for (int k = 0; k < chb.size(); k++)
      b_ws.push_back((k + 1 < chb.size()) ? chb[k+1] : chb[k]);
    w_ch.delete(); w_val.delete(); w_n.delete();
  endfunction

  task automatic tx_low(input bit w, input bit d);
    sck = 0; ws = w; sd = d;
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_high(input bit w, input bit d);
    sck = 1; model_bit(w, d);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_range(input int a, input int b);
    for (int k = a; k <= b; k++) begin
      tx_low(b_ws[k], b_sd[k]);
      tx_high(b_ws[k], b_sd[k]);
    end
  endtask

  task automatic idle();
    sck = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, rx_if.out_valid, 0);
    chk({tag, "_left"}, rx_if.out_left, 0);
    chk({tag, "_right"}, rx_if.out_right, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_short"}, short_err, 0);
  endtask

  task automatic do_reset();
    rdy_mode = 0; rx_if.out_ready = 0;
    rst_n = 0; model_reset(); exp_l.delete(); exp_r.delete();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    @(negedge clk);
    short_base = short_cnt;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_l.size() != 0; i++) @(negedge clk);
    chk("drain_pending", exp_l.size(), 0);
    @(negedge clk);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (short_err) short_cnt++;
      if (rdy_mode != 3) begin
        mon_r = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
        rx_if.out_ready = mon_r;
        if (mon_r && rx_if.out_valid) begin
          if (exp_l.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pair actual=%h/%h required=none",
                     rx_if.out_left, rx_if.out_right);
          end else begin
            chk("pair_left", rx_if.out_left, exp_l.pop_front());
            chk("pair_right", rx_if.out_right, exp_r.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    bit ch;
    fork monitor(); join_none
    m_en = 1; m_push = 0; rx_if.out_ready = 0;

    vecs[0] = '{32'hA5C3,   16, 32'h1234,   16, 16'hA5C3, 16'h1234, 0};
    vecs[1] = '{32'hABCDEF, 24, 32'h123456, 24, 16'hABCD, 16'h1234, 0};
    vecs[2] = '{32'hFFF,    12, 32'h800,    12, 16'hFFF0, 16'h8000, 4};
    vecs[3] = '{32'h1,       1, 32'h0,       1, 16'h8000, 16'h0000, 4};
    vecs[4] = '{32'h1FFFF,  17, 32'h00001,  17, 16'hFFFF, 16'h0000, 0};
    vecs[5] = '{32'h8001,   16, 32'h7FFE,   16, 16'h8001, 16'h7FFE, 0};

    // Each vector: preamble frame (consumed by sync), two frames, a trailing bit.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      rdy_mode = 1;
      add_word(0, 0, 16); add_word(1, 0, 16);
      for (int f = 0; f < 2; f++) begin
        add_word(0, vecs[v].l_in, vecs[v].l_n);
        add_word(1, vecs[v].r_in, vecs[v].r_n);
        exp_l.push_back(vecs[v].exp_l); exp_r.push_back(vecs[v].exp_r);
      end
      add_word(0, 0, 1);
      build(); send_range(0, b_sd.size() - 1); idle();
      wait_drain();
      chk("vec_short_cnt", short_cnt - short_base, vecs[v].exp_short);
      chk("vec_level", fifo_level, 0);
      chk("vec_ovf", overflow, 0);
    end

    // out_valid timing around the right-word LSB rise.
    do_reset();
    rdy_mode = 1;
    add_word(0, 0, 16); add_word(1, 0, 16);
    add_word(0, 32'hA5C3, 16); add_word(1, 32'h1234, 16); add_word(0, 0, 1);
    exp_l.push_back(16'hA5C3); exp_r.push_back(16'h1234);
    build(); send_range(0, 62);
    tx_low(b_ws[63], b_sd[63]);
    sck = 1; model_bit(b_ws[63], b_sd[63]);
    @(posedge clk); @(posedge clk); #1;
    chk("valid_before_push", rx_if.out_valid, 0);
    @(posedge clk); #1;
    chk("valid_after_push", rx_if.out_valid, 1);
    @(negedge clk); @(negedge clk);
    send_range(64, 64); idle();
    wait_drain();

    // Overflow: five frames into a four-deep FIFO with no reads.
    do_reset();
    add_word(0, 0, 16); add_word(1, 0, 16);
    for (int i = 0; i < 5; i++) begin
      add_word(0, 32'h1000 + i, 16); add_word(1, 32'h2000 + i, 16);
      if (i < 4) begin exp_l.push_back(16'h1000 + i); exp_r.push_back(16'h2000 + i); end
    end
    add_word(0, 0, 1);
    build(); send_range(0, b_sd.size() - 1); idle();
    chk("ovf_level", fifo_level, 4);
    chk("ovf_set", overflow, 1);
    rdy_mode = 1;
    wait_drain();
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1; @(negedge clk); ovf_clr = 0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO: pop lands on the same edge as the push of a fifth pair.
    do_reset();
    rdy_mode = 3;
    add_word(0, 0, 16); add_word(1, 0, 16);
    for (int i = 0; i < 5; i++) begin
      add_word(0, 32'h3000 + i, 16); add_word(1, 32'h4000 + i, 16);
      exp_l.push_back(16'h3000 + i); exp_r.push_back(16'h4000 + i);
    end
    add_word(0, 0, 1);
    build(); send_range(0, 190);
    chk("full_level", fifo_level, 4);
    tx_low(b_ws[191], b_sd[191]);
    sck = 1; model_bit(b_ws[191], b_sd[191]);
    repeat (2) @(negedge clk);
    chk("full_head_left", rx_if.out_left, exp_l.pop_front());
    chk("full_head_right", rx_if.out_right, exp_r.pop_front());
    rx_if.out_ready = 1;
    @(negedge clk);
    rx_if.out_ready = 0;
    chk("pushpop_level", fifo_level, 4);
    chk("pushpop_ovf", overflow, 0);
    @(negedge clk);
    send_range(192, 192); idle();
    rdy_mode = 1;
    wait_drain();

    // Reset in the middle of a right word, then two frames.
    do_reset();
    rdy_mode = 1;
    add_word(0, 0, 16); add_word(1, 0, 16);
    add_word(0, 32'h1111, 16); add_word(1, 32'h2222, 16);
    add_word(0, 32'h3333, 16); add_word(1, 32'h4444, 16);
    add_word(0, 32'h5555, 16); add_word(1, 32'h6666, 16);
    build(); send_range(0, 55);
    tx_low(b_ws[56], b_sd[56]);
    rst_n = 0; model_reset();
    repeat (2) @(negedge clk);
    check_zero("midreset");
    rst_n = 1;
    repeat (2) @(negedge clk);
    short_base = short_cnt;
    exp_l.push_back(16'h3333); exp_r.push_back(16'h4444);
    tx_high(b_ws[56], b_sd[56]);
    send_range(57, 127); idle();
    wait_drain();
    repeat (20) @(negedge clk);
    chk("midreset_level", fifo_level, 0);
    chk("midreset_short", short_cnt - short_base, 1);

    // Enable dropped mid right word: FIFO stays readable, then resync.
    do_reset();
    add_word(0, 0, 16); add_word(1, 0, 16);
    for (int i = 1; i <= 4; i++) begin
      add_word(0, 32'h1111 * (2 * i - 1), 16); add_word(1, 32'h1111 * (2 * i), 16);
    end
    add_word(0, 0, 1);
    build(); send_range(0, 87);
    en = 0; m_en = 0; m_sync = 0; m_lvld = 0; m_bits.delete();
    @(negedge clk);
    chk("en_low_level", fifo_level, 1);
    chk("en_low_valid", rx_if.out_valid, 1);
    send_range(88, 91);
    en = 1; m_en = 1;
    send_range(92, b_sd.size() - 1); idle();
    chk("en_resume_level", fifo_level, 3);
    exp_l.push_back(16'h1111); exp_r.push_back(16'h2222);
    exp_l.push_back(16'h5555); exp_r.push_back(16'h6666);
    exp_l.push_back(16'h7777); exp_r.push_back(16'h8888);
    rdy_mode = 1;
    wait_drain();
    chk("en_short", short_cnt - short_base, 0);

    // Randomized word streams with occasional missing WS toggles.
    for (int s = 0; s < 3; s++) begin
      do_reset();
      m_push = 1;
      rdy_mode = 2;
      ch = 0;
      for (int i = 0; i < 40; i++) begin
        add_word(ch, $urandom, $urandom_range(1, 24));
        last = ch;
        if ($urandom_range(0, 9) != 0) ch = ~ch;
      end
      add_word(~last[0], 0, 1);
      build(); send_range(0, b_sd.size() - 1); idle();
      wait_drain();
      chk("rand_short_cnt", short_cnt - short_base, m_short);
      chk("rand_ovf", overflow, 0);
      m_push = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
